// File: rtl/sr_decomp_if.sv
// Handshake bundle for sr_decomp: header flag, payload word stream and reconstructed beat stream.
interface sr_decomp_if;
   logic        hdr_valid_i;
   logic        hdr_flag_i;
   logic        hdr_ready_o;
   logic [63:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic [63:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        last_o;
   logic        err_o;

   modport master (
      output hdr_valid_i, hdr_flag_i, data_i, valid_i, ready_i,
      input  hdr_ready_o, ready_o, data_o, valid_o, last_o, err_o
   );

   modport slave (
      input  hdr_valid_i, hdr_flag_i, data_i, valid_i, ready_i,
      output hdr_ready_o, ready_o, data_o, valid_o, last_o, err_o
   );
endinterface

// File: rtl/sr_decomp.sv
// Sign-reduction block decoder: expands packed 32-bit beats to 4 x 16-bit lanes or passes raw blocks.
// Optional first-word marker check is enabled by the SR_DEC_CHK_EN macro.
module sr_decomp #(
   parameter int BLK_BEATS = 16
) (
   input logic        clk,
   input logic        rst,
   sr_decomp_if.slave bus
);
   localparam int CW = (BLK_BEATS > 2) ? $clog2(BLK_BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BLK_BEATS - 1);

   typedef enum logic [1:0] {
      S_HDR = 2'd0,
      S_RAW = 2'd1,
      S_CMP = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   hold;
   logic          half_pend;
   logic [63:0]   data_q;
   logic          valid_q;
   logic          last_q;
   logic          out_free;
   logic          ready;
   logic          word_acc;
   logic          hdr_acc;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   // Beat 0 of a compressed block carries a marker in bit 31, so lane3 is only 7 bits wide.
   function automatic logic [63:0] expand(input logic [31:0] b, input logic first);
      logic [15:0] l3;
      if (first) begin
         l3 = {{9{b[30]}}, b[30:24]};
      end else begin
         l3 = sext8(b[31:24]);
      end
      return {l3, sext8(b[23:16]), sext8(b[15:8]), sext8(b[7:0])};
   endfunction

   assign out_free = ~valid_q | bus.ready_i;
   assign word_acc = bus.valid_i & ready;
   assign hdr_acc  = bus.hdr_valid_i & (state == S_HDR);

   // Payload ready decode per state.
   always_comb begin
      ready = 1'b0;
      case (state)
         S_RAW:   ready = out_free;
         S_CMP:   ready = out_free & ~half_pend;
         default: ready = 1'b0;
      endcase
   end

   // Block FSM, beat counter, half-beat hold and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_HDR;
         cnt       <= {CW{1'b0}};
         hold      <= 32'd0;
         half_pend <= 1'b0;
         data_q    <= 64'd0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         if (valid_q && bus.ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
         case (state)
            S_HDR: begin
               if (hdr_acc) begin
                  state <= bus.hdr_flag_i ? S_RAW : S_CMP;
                  cnt   <= {CW{1'b0}};
               end
            end
            S_RAW: begin
               if (word_acc) begin
                  data_q  <= bus.data_i;
                  valid_q <= 1'b1;
                  last_q  <= (cnt == LAST_BEAT);
                  if (cnt == LAST_BEAT) begin
                     state <= S_HDR;
                     cnt   <= {CW{1'b0}};
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_CMP: begin
               if (half_pend) begin
                  if (out_free) begin
                     data_q    <= expand(hold, 1'b0);
                     valid_q   <= 1'b1;
                     last_q    <= (cnt == LAST_BEAT);
                     half_pend <= 1'b0;
                     if (cnt == LAST_BEAT) begin
                        state <= S_HDR;
                        cnt   <= {CW{1'b0}};
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
               end else if (word_acc) begin
                  // High half is always an even beat, so it can never be the last one.
                  data_q    <= expand(bus.data_i[63:32], cnt == {CW{1'b0}});
                  valid_q   <= 1'b1;
                  last_q    <= 1'b0;
                  hold      <= bus.data_i[31:0];
                  half_pend <= 1'b1;
                  cnt       <= cnt + CW'(1);
               end
            end
            default: begin
               state     <= S_HDR;
               cnt       <= {CW{1'b0}};
               half_pend <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hdr_ready_o = (state == S_HDR);
   assign bus.ready_o     = ready;
   assign bus.data_o      = data_q;
   assign bus.valid_o     = valid_q;
   assign bus.last_o      = last_q;

`ifdef SR_DEC_CHK_EN
   logic err_q;

   // Marker check: the first word of a compressed block must have bit 63 set.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= word_acc & (state == S_CMP) & (cnt == {CW{1'b0}}) & ~bus.data_i[63];
      end
   end

   assign bus.err_o = err_q;
`else
   assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sr_decomp.sv
// Self-checking bench for sr_decomp: vector tables plus scoreboard of expected output beats.
module tb_sr_decomp;
   logic clk = 1'b0;
   logic rst;

   sr_decomp_if bus_if();

   sr_decomp #(.BLK_BEATS(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

`ifdef SR_DEC_CHK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   typedef struct {
      logic [63:0] word;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
   } vec_t;

   exp_t        sb[$];
   vec_t        first_tbl[3];
   vec_t        tbl[7];
   int          vectors = 0;
   int          miscompares = 0;
   int          beats_seen = 0;
   logic        stall = 1'b0;
   logic [63:0] s_data;
   logic        s_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] d, input logic l);
      exp_t e;
      e.data = d;
      e.last = l;
      sb.push_back(e);
   endtask

   // Output monitor: scoreboard pop on handshake, stability check while stalled.
   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("hold_valid", {63'd0, bus_if.valid_o}, 64'd1);
            check("hold_data", bus_if.data_o, s_data);
            check("hold_last", {63'd0, bus_if.last_o}, {63'd0, s_last});
         end
         if (bus_if.valid_o && bus_if.ready_i) begin
            beats_seen++;
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_beat: got %h expected no beat", bus_if.data_o);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("beat_data", bus_if.data_o, e.data);
               check("beat_last", {63'd0, bus_if.last_o}, {63'd0, e.last});
            end
         end
         stall  = bus_if.valid_o && !bus_if.ready_i;
         s_data = bus_if.data_o;
         s_last = bus_if.last_o;
      end
   end

   task automatic send_hdr(input logic flag);
      logic done;
      done = 1'b0;
      bus_if.hdr_flag_i  = flag;
      bus_if.hdr_valid_i = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         if (bus_if.hdr_ready_o) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      bus_if.hdr_valid_i = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL hdr_timeout: got no hdr_ready_o expected handshake");
      end
   endtask

   task automatic send_word(input logic [63:0] w, output int waits);
      logic done;
      done  = 1'b0;
      waits = 0;
      bus_if.data_i  = w;
      bus_if.valid_i = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         if (bus_if.ready_o) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end else begin
            waits++;
         end
      end
      bus_if.valid_i = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL word_timeout: got no ready_o expected handshake");
      end
   endtask

   task automatic cmp_first(input int idx);
      int w;
      send_hdr(1'b0);
      push(first_tbl[idx].exp_a, 1'b0);
      push(first_tbl[idx].exp_b, 1'b0);
      send_word(first_tbl[idx].word, w);
   endtask

   task automatic send_cmp(input int k, output int waits);
      push(tbl[k].exp_a, 1'b0);
      push(tbl[k].exp_b, k == 6);
      send_word(tbl[k].word, waits);
   endtask

   task automatic cmp_rest(output int waits);
      int w;
      waits = 0;
      for (int k = 0; k < 7; k++) begin
         send_cmp(k, w);
         waits += w;
      end
   endtask

   task automatic raw_block(input logic [63:0] base, output int waits);
      int w;
      waits = 0;
      send_hdr(1'b1);
      for (int i = 0; i < 16; i++) begin
         push(base + 64'(i), i == 15);
         send_word(base + 64'(i), w);
         waits += w;
      end
   endtask

   task automatic drain(input string name, input int b0);
      for (int t = 0; t < 64 && sb.size() != 0; t++) @(posedge clk);
      #2;
      check({name, "_drain"}, 64'(sb.size()), 64'd0);
      check({name, "_beats"}, 64'(beats_seen - b0), 64'd16);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int b0;

      first_tbl[0] = '{64'h81FF7F80_01020304, 64'h0001FFFF_007FFF80, 64'h00010002_00030004};
      first_tbl[1] = '{64'hC0000000_00000000, 64'hFFC00000_00000000, 64'h00000000_00000000};
      first_tbl[2] = '{64'h7F000000_00000000, 64'hFFFF0000_00000000, 64'h00000000_00000000};
      tbl[0] = '{64'h01020304_05060708, 64'h00010002_00030004, 64'h00050006_00070008};
      tbl[1] = '{64'h80FF7F00_FFFFFFFF, 64'hFF80FFFF_007F0000, 64'hFFFFFFFF_FFFFFFFF};
      tbl[2] = '{64'h00000000_80808080, 64'h00000000_00000000, 64'hFF80FF80_FF80FF80};
      tbl[3] = '{64'h7F7F7F7F_12345678, 64'h007F007F_007F007F, 64'h00120034_00560078};
      tbl[4] = '{64'hDEADBEEF_CAFEF00D, 64'hFFDEFFAD_FFBEFFEF, 64'hFFCAFFFE_FFF0000D};
      tbl[5] = '{64'h40C03FBF_00000001, 64'h0040FFC0_003FFFBF, 64'h00000000_00000001};
      tbl[6] = '{64'h11223344_99AABBCC, 64'h00110022_00330044, 64'hFF99FFAA_FFBBFFCC};

      rst                = 1'b1;
      bus_if.hdr_valid_i = 1'b0;
      bus_if.hdr_flag_i  = 1'b0;
      bus_if.data_i      = 64'd0;
      bus_if.valid_i     = 1'b0;
      bus_if.ready_i     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {63'd0, bus_if.valid_o}, 64'd0);
      check("rst_last", {63'd0, bus_if.last_o}, 64'd0);
      check("rst_data", bus_if.data_o, 64'd0);
      check("rst_err", {63'd0, bus_if.err_o}, 64'd0);
      check("rst_hdr_ready", {63'd0, bus_if.hdr_ready_o}, 64'd1);
      check("rst_ready", {63'd0, bus_if.ready_o}, 64'd0);
      rst = 1'b0;

      // Compressed block with marker example, full rate downstream.
      b0 = beats_seen;
      cmp_first(0);
      check("cmp_ready_after_acc", {63'd0, bus_if.ready_o}, 64'd0);
      check("cmp_err_quiet", {63'd0, bus_if.err_o}, 64'd0);
      cmp_rest(w);
      check("cmp_rate_waits", 64'(w), 64'd7);
      drain("cmp1", b0);
      check("cmp1_hdr_ready", {63'd0, bus_if.hdr_ready_o}, 64'd1);

      // Compressed block whose beat 0 lane3 is sign-extended from bit 30.
      b0 = beats_seen;
      cmp_first(1);
      cmp_rest(w);
      drain("cmp2", b0);
      check("cmp2_hdr_ready", {63'd0, bus_if.hdr_ready_o}, 64'd1);

      // Raw block: identity, one word per cycle.
      b0 = beats_seen;
      raw_block(64'h01234567_89ABCDE0, w);
      check("raw_back_hdr", {63'd0, bus_if.hdr_ready_o}, 64'd1);
      check("raw_rate_waits", 64'(w), 64'd0);
      drain("raw1", b0);

      // Downstream stall of 3 cycles mid compressed block.
      b0 = beats_seen;
      fork
         begin
            cmp_first(0);
            cmp_rest(w);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            bus_if.ready_i = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("bp_ready_low", {63'd0, bus_if.ready_o}, 64'd0);
               @(posedge clk);
               #1;
            end
            bus_if.ready_i = 1'b1;
         end
      join
      drain("bp", b0);

      // Reset mid compressed block discards the partial block.
      cmp_first(0);
      send_cmp(0, w);
      send_cmp(1, w);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      check("mid_rst_valid", {63'd0, bus_if.valid_o}, 64'd0);
      check("mid_rst_hdr_ready", {63'd0, bus_if.hdr_ready_o}, 64'd1);
      check("mid_rst_last", {63'd0, bus_if.last_o}, 64'd0);
      rst = 1'b0;
      b0 = beats_seen;
      raw_block(64'hFEDCBA98_76543210, w);
      drain("raw2", b0);

      // Missing marker on the first compressed word.
      b0 = beats_seen;
      cmp_first(2);
      check("err_pulse", {63'd0, bus_if.err_o}, {63'd0, CHK});
      check("err_with_valid", {63'd0, bus_if.valid_o}, 64'd1);
      @(posedge clk);
      #1;
      check("err_one_cycle", {63'd0, bus_if.err_o}, 64'd0);
      cmp_rest(w);
      drain("err_blk", b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sr_decomp.md
Name: sr_decomp

Overview:
- Sign-reduction decoder. It is the receive-side inverse of the team's SR compressor.
- Consumes a per-block header flag, then the block payload:
  - flag=0: 8 packed 64-bit words, each holding two 32-bit reduced beats.
  - flag=1: 16 raw 64-bit words.
- Emits 16 reconstructed 64-bit beats per block, each beat being 4 x 16-bit lanes.
- Sits between the bit-plane payload unpacker and the consumer datapath.

Parameters:
- BLK_BEATS, 16, output beats per block; must be even and >=2. Compressed words per block = BLK_BEATS/2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- hdr_valid_i  input  1  header flag valid.
- hdr_flag_i  input  1  1 = block is raw, 0 = block is sign-reduced.
- hdr_ready_o  output  1  header accepted when hdr_valid_i & hdr_ready_o.
- data_i  input  64  payload word.
- valid_i  input  1  payload valid.
- ready_o  output  1  payload accepted when valid_i & ready_o.
- data_o  output  64  reconstructed beat {lane3,lane2,lane1,lane0}.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream ready.
- last_o  output  1  data_o is beat BLK_BEATS-1 of its block.
- err_o  output  1  marker error pulse; present only with SR_DEC_CHK_EN, otherwise tied 0.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=S_HDR; beat counter=0; hold register cleared.
  - Outputs: valid_o=0, last_o=0, data_o=0, err_o=0.
  - Any partial block is discarded.
- States:
  - S_HDR:
    - hdr_ready_o=1, ready_o=0.
    - On header handshake: go to S_RAW if flag=1, else S_CMP; clear beat counter.
  - S_RAW:
    - ready_o = ~valid_o | ready_i.
    - An accepted word is registered unchanged to data_o next cycle.
    - On acceptance of beat BLK_BEATS-1, go to S_HDR.
  - S_CMP:
    - ready_o = (~valid_o | ready_i) & ~half_pend.
    - An accepted word c is split: beat A = c[63:32] goes to the output register next cycle; beat B = c[31:0] goes to the hold register and sets half_pend.
  - S_CMP, half_pend=1:
    - When the output register is free or being consumed, beat B moves to output and half_pend clears.
    - If that was beat BLK_BEATS-1, go to S_HDR.
- Expansion of a 32-bit beat b:
  - lane3 = sext8(b[31:24]), lane2 = sext8(b[23:16]), lane1 = sext8(b[15:8]), lane0 = sext8(b[7:0]).
  - sext8 replicates bit 7 into bits 15:8.
- First beat of each compressed block (beat 0): b[31] is a marker bit, not data. lane3 = sext7(b[30:24]), i.e. b[30] is replicated into bits 15:7.
- Latency: 1 cycle from input handshake to valid_o.
- Throughput: raw 1 beat/cycle; compressed 1 input word per 2 cycles, 1 output beat/cycle.
- Output hold: while valid_o & ~ready_i, data_o and last_o are held stable.
- last_o is asserted with the beat whose counter = BLK_BEATS-1. The counter wraps to 0 on entering S_HDR.
- The next header may be accepted while the final beat is still pending on the output.
- valid_i or data are ignored in S_HDR; ready_o=0 there.
- hdr_valid_i is ignored outside S_HDR; hdr_ready_o=0 there.

Optional Feature:
- Macro: SR_DEC_CHK_EN.
- Defined:
  - In S_CMP, on acceptance of a block's first word, if c[63]==0, err_o pulses high for exactly 1 cycle, coincident with valid_o of beat 0.
  - Decoding proceeds unchanged.
- Undefined: no check logic; err_o is constant 0.

Test Plan:
- Header flag=0, first word 0x81FF7F80_01020304, ready_i=1:
  - beat0 = 0x0001_FFFF_007F_FF80;
  - beat1 = 0x0001_0002_0003_0004;
  - ready_o low the cycle after acceptance.
- Header flag=0, first word byte 0xC0 at [63:56] with remaining bytes 0: beat0 lane3 = 0xFFC0. Send 8 words total: 16 beats out, last_o only on the 16th, hdr_ready_o high afterwards.
- Header flag=1, 16 words 0x0123456789ABCDE0+i: outputs are identical and in order, 1 per cycle, last_o on word 15, then return to S_HDR.
- Backpressure: ready_i=0 for 3 cycles during a compressed block → data_o, valid_o and last_o stable, ready_o=0, no beat lost or duplicated; total output = 16 beats.
- rst=1 after 5 beats of a compressed block → next cycle valid_o=0, hdr_ready_o=1. A fresh raw block then decodes correctly from beat 0.
- SR_DEC_CHK_EN defined, flag=0, first word 0x7F000000_00000000 → err_o=1 for 1 cycle with beat0 = 0xFFFF_0000_0000_0000. Without the macro, err_o stays 0.
